// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES chunks of
// WIDTH/STAGES bits, one chunk resolved per register stage, with valid/ready flow control.
module adder_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = WIDTH / STAGES;

  logic             w_en;
  logic [WIDTH-1:0] w_b_cond;

  // The whole pipe advances as one; a full output register blocks everything behind it.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  assign w_b_cond = sub ? ~in2 : in2;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be summed on entry, and result bits known on exit.
      localparam int REM  = WIDTH - k * CW;
      localparam int DONE = (k + 1) * CW;

      logic [REM-1:0]  w_a;
      logic [REM-1:0]  w_b;
      logic            w_cin;
      logic            w_vin;
      logic [CW:0]     w_sum;
      logic [DONE-1:0] w_res_next;
      logic            r_vld;
      logic            r_cy;
      logic [DONE-1:0] r_res;

      if (k == 0) begin : g_head
        assign w_a        = in1;
        assign w_b        = w_b_cond;
        assign w_cin      = sub;
        assign w_vin      = in_valid;
        assign w_res_next = w_sum[CW-1:0];
      end else begin : g_body
        assign w_a        = g_stage[k-1].g_pass.r_a;
        assign w_b        = g_stage[k-1].g_pass.r_b;
        assign w_cin      = g_stage[k-1].r_cy;
        assign w_vin      = g_stage[k-1].r_vld;
        assign w_res_next = {w_sum[CW-1:0], g_stage[k-1].r_res};
      end

      assign w_sum = {1'b0, w_a[CW-1:0]} + {1'b0, w_b[CW-1:0]} + {{CW{1'b0}}, w_cin};

      // Stage occupancy: bubbles are shifted in like data, never squeezed out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
        end else if (w_en) begin
          r_vld <= w_vin;
        end else begin
          r_vld <= r_vld;
        end
      end

      // Chunk sum and carry; data only moves with a valid entry so outputs never go X.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cy  <= 1'b0;
          r_res <= '0;
        end else if (w_en && w_vin) begin
          r_cy  <= w_sum[CW];
          r_res <= w_res_next;
        end else begin
          r_cy  <= r_cy;
          r_res <= r_res;
        end
      end

      if (k < STAGES - 1) begin : g_pass
        logic [REM-CW-1:0] r_a;
        logic [REM-CW-1:0] r_b;

        // Unconsumed operand chunks ride along, shifted so the next chunk sits at bit 0.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_en && w_vin) begin
            r_a <= w_a[REM-1:CW];
            r_b <= w_b[REM-1:CW];
          end else begin
            r_a <= r_a;
            r_b <= r_b;
          end
        end
      end

      if (k == STAGES - 1) begin : g_tail
        logic r_ovf;

        // Carry into the MSB is recovered as a ^ b ^ sum at the top bit.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ovf <= 1'b0;
          end else if (w_en && w_vin) begin
            r_ovf <= w_sum[CW] ^ w_a[CW-1] ^ w_b[CW-1] ^ w_sum[CW-1];
          end else begin
            r_ovf <= r_ovf;
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign out       = g_stage[STAGES-1].r_res;
  assign carry     = g_stage[STAGES-1].r_cy;
  assign overflow  = g_stage[STAGES-1].g_tail.r_ovf;

endmodule
